// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: address map, op encodings,
// mstatus bit positions and small decode/modify helpers.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_MSTATUS,
        SEL_MTVEC,
        SEL_MSCRATCH,
        SEL_MEPC,
        SEL_MCAUSE,
        SEL_MCYCLE,
        SEL_MCYCLEH,
        SEL_MINSTRET,
        SEL_MINSTRETH
    } csr_sel_e;

    // User-level counter aliases decode to the same selector as their machine twins;
    // the read-only check is done separately on addr[11:10].
    function automatic csr_sel_e csr_decode(input logic [11:0] addr);
        csr_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            CSR_MSTATUS:                 sel = SEL_MSTATUS;
            CSR_MTVEC:                   sel = SEL_MTVEC;
            CSR_MSCRATCH:                sel = SEL_MSCRATCH;
            CSR_MEPC:                    sel = SEL_MEPC;
            CSR_MCAUSE:                  sel = SEL_MCAUSE;
            CSR_MCYCLE,    CSR_CYCLE:    sel = SEL_MCYCLE;
            CSR_MCYCLEH,   CSR_CYCLEH:   sel = SEL_MCYCLEH;
            CSR_MINSTRET,  CSR_INSTRET:  sel = SEL_MINSTRET;
            CSR_MINSTRETH, CSR_INSTRETH: sel = SEL_MINSTRETH;
            default:                     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] csr_modify(input logic [1:0]  op,
                                               input logic [31:0] old,
                                               input logic [31:0] operand);
        logic [31:0] res;
        res = old;
        case (op)
            CSR_OP_RW: res = operand;
            CSR_OP_RS: res = old | operand;
            CSR_OP_RC: res = old & ~operand;
            default:   res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent 32-bit half writes.
// A write to either half replaces it and suppresses that cycle's increment.
module csr_counter64 #(
    parameter bit EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) cnt_d[31:0]  = wdata_i;
        if (wr_hi_i) cnt_d[63:32] = wdata_i;
        if (!wr_lo_i && !wr_hi_i && inc_i) cnt_d = cnt_q + 64'd1;
        if (!EN) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: zero-latency read, RW/RS/RC write, trap entry and MRET.
// Writes, traps and MRET take effect on the next rising edge; reads have no bypass.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              COUNTERS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_operand,
    input  logic            csr_wr_skip,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_out
);

    localparam logic [XLEN-1:0] ALIGN4_MASK = ~(XLEN'(3));

    logic            mie_q,      mie_d;
    logic            mpie_q,     mpie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;

    logic [63:0]     mcycle_cnt;
    logic [63:0]     minstret_cnt;

    csr_sel_e        sel;
    logic            we_raw;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mstatus_val;

    assign sel = csr_decode(csr_addr);

    always_comb begin
        mstatus_val           = '0;
        mstatus_val[MIE_BIT]  = mie_q;
        mstatus_val[MPIE_BIT] = mpie_q;
    end

    always_comb begin
        csr_rdata = '0;
        case (sel)
            SEL_MSTATUS:   csr_rdata = mstatus_val;
            SEL_MTVEC:     csr_rdata = mtvec_q;
            SEL_MSCRATCH:  csr_rdata = mscratch_q;
            SEL_MEPC:      csr_rdata = mepc_q;
            SEL_MCAUSE:    csr_rdata = mcause_q;
            SEL_MCYCLE:    csr_rdata = mcycle_cnt[31:0];
            SEL_MCYCLEH:   csr_rdata = mcycle_cnt[63:32];
            SEL_MINSTRET:  csr_rdata = minstret_cnt[31:0];
            SEL_MINSTRETH: csr_rdata = minstret_cnt[63:32];
            default:       csr_rdata = '0;
        endcase
    end

    // x0 as source only suppresses the write for set/clear; RW with x0 still writes zero.
    assign we_raw = csr_en && (csr_op != CSR_OP_NONE)
                 && !((csr_op != CSR_OP_RW) && csr_wr_skip);

    assign csr_illegal = csr_en && ((sel == SEL_NONE)
                                 || ((csr_addr[11:10] == 2'b11) && we_raw));

    assign we    = we_raw && !csr_illegal;
    assign wdata = csr_modify(csr_op, csr_rdata, csr_operand);

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;

        if (we) begin
            case (sel)
                SEL_MSTATUS: begin
                    mie_d  = wdata[MIE_BIT];
                    mpie_d = wdata[MPIE_BIT];
                end
                SEL_MTVEC:    mtvec_d    = wdata & ALIGN4_MASK;
                SEL_MSCRATCH: mscratch_d = wdata;
                SEL_MEPC:     mepc_d     = wdata & ALIGN4_MASK;
                SEL_MCAUSE:   mcause_d   = wdata;
                default: ;
            endcase
        end

        // Hardware events override any software write to the same registers.
        if (trap_take) begin
            mepc_d   = trap_pc & ALIGN4_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN4_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    csr_counter64 #(.EN(COUNTERS_EN)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (we && (sel == SEL_MCYCLE)),
        .wr_hi_i (we && (sel == SEL_MCYCLEH)),
        .wdata_i (wdata),
        .cnt_o   (mcycle_cnt)
    );

    csr_counter64 #(.EN(COUNTERS_EN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instr_retire),
        .wr_lo_i (we && (sel == SEL_MINSTRET)),
        .wr_hi_i (we && (sel == SEL_MINSTRETH)),
        .wdata_i (wdata),
        .cnt_o   (minstret_cnt)
    );

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: stimulus queues expected values tagged with a cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] MTVEC_EXP = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_operand = '0;
    logic        csr_wr_skip = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        trap_take = 1'b0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_cause = '0;
    logic        mret = 1'b0;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    csr_unit #(
        .XLEN        (32),
        .MTVEC_RESET (MTVEC_RST),
        .COUNTERS_EN (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_en       (csr_en),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_operand  (csr_operand),
        .csr_wr_skip  (csr_wr_skip),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_take    (trap_take),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .mret         (mret),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .mie_out      (mie_out)
    );

    always #5 clk = ~clk;

    typedef enum int {K_RDATA, K_ILL, K_MTVEC, K_MEPC, K_MIE} kind_e;
    typedef struct {
        int          cyc;
        int          tag;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   tag    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input kind_e k);
        case (k)
            K_RDATA: return "csr_rdata";
            K_ILL:   return "csr_illegal";
            K_MTVEC: return "mtvec_out";
            K_MEPC:  return "mepc_out";
            default: return "mie_out";
        endcase
    endfunction

    task automatic expect_v(input kind_e k, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.tag  = tag;
        e.kind = k;
        e.val  = v;
        sb_q.push_back(e);
        tag++;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.kind)
                K_RDATA: act = csr_rdata;
                K_ILL:   act = {31'd0, csr_illegal};
                K_MTVEC: act = mtvec_out;
                K_MEPC:  act = mepc_out;
                default: act = {31'd0, mie_out};
            endcase
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL chk%0d %s: sampled late (cycle %0d, due %0d)",
                         e.tag, kname(e.kind), cyc, e.cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL chk%0d %s: got 0x%08h, expected 0x%08h",
                         e.tag, kname(e.kind), act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        csr_en       = 1'b0;
        csr_op       = 2'b00;
        csr_operand  = '0;
        csr_wr_skip  = 1'b0;
        instr_retire = 1'b0;
        trap_take    = 1'b0;
        mret         = 1'b0;
    endtask

    task automatic csr_acc(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] operand, input logic skip);
        csr_en      = 1'b1;
        csr_op      = op;
        csr_addr    = addr;
        csr_operand = operand;
        csr_wr_skip = skip;
    endtask

    initial begin
        #2 rst = 1'b0;

        // Held in reset
        step();
        csr_addr = 12'h305;
        expect_v(K_RDATA, MTVEC_EXP);
        expect_v(K_MTVEC, MTVEC_EXP);
        expect_v(K_MEPC, 32'h0);
        expect_v(K_MIE, 32'h0);
        expect_v(K_ILL, 32'h0);

        step();
        rst = 1'b1;
        csr_addr = 12'hB00;
        expect_v(K_RDATA, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1 || k == 5) expect_v(K_RDATA, k);
        end
        step();
        csr_addr = 12'hB02;
        expect_v(K_RDATA, 32'd0);

        // mscratch read-modify-write
        step(); csr_acc(2'b01, 12'h340, 32'hA5A5_0000, 1'b0); expect_v(K_ILL, 32'h0);
        step(); csr_acc(2'b10, 12'h340, 32'h0000_00FF, 1'b0); expect_v(K_RDATA, 32'hA5A5_0000);
        step(); csr_acc(2'b11, 12'h340, 32'hA500_0000, 1'b0); expect_v(K_RDATA, 32'hA5A5_00FF);
        step(); csr_acc(2'b10, 12'h340, 32'hFFFF_FFFF, 1'b1); expect_v(K_RDATA, 32'h00A5_00FF);
        step(); csr_addr = 12'h340; expect_v(K_RDATA, 32'h00A5_00FF);

        // mtvec write drops the low two bits
        step(); csr_acc(2'b01, 12'h305, 32'h0000_2003, 1'b0);
        step(); expect_v(K_MTVEC, 32'h0000_2000);

        // Illegal accesses
        step(); csr_acc(2'b01, 12'hB00, 32'd100, 1'b0);
        step(); csr_acc(2'b01, 12'hC00, 32'd0, 1'b0);
        expect_v(K_ILL, 32'h1); expect_v(K_RDATA, 32'd100);
        step(); csr_addr = 12'hB00; expect_v(K_RDATA, 32'd101);
        step(); csr_acc(2'b10, 12'hC00, 32'hFFFF_FFFF, 1'b1);
        expect_v(K_ILL, 32'h0); expect_v(K_RDATA, 32'd102);
        step(); csr_acc(2'b00, 12'h7FF, 32'h0, 1'b0);
        expect_v(K_ILL, 32'h1); expect_v(K_RDATA, 32'h0);
        step(); csr_acc(2'b00, 12'hC82, 32'h0, 1'b0);
        expect_v(K_ILL, 32'h0); expect_v(K_RDATA, 32'h0);

        // Trap entry and MRET
        step(); csr_acc(2'b10, 12'h300, 32'h8, 1'b0); expect_v(K_RDATA, 32'h0);
        step(); csr_addr = 12'h300; expect_v(K_RDATA, 32'h8); expect_v(K_MIE, 32'h1);
        step(); trap_take = 1'b1; trap_pc = 32'h0000_1236; trap_cause = 32'hB;
        step(); csr_addr = 12'h300;
        expect_v(K_RDATA, 32'h80); expect_v(K_MIE, 32'h0); expect_v(K_MEPC, 32'h1234);
        step(); csr_addr = 12'h342; expect_v(K_RDATA, 32'hB);
        step(); csr_addr = 12'h341; expect_v(K_RDATA, 32'h1234);
        step(); mret = 1'b1;
        step(); csr_addr = 12'h300; expect_v(K_RDATA, 32'h88); expect_v(K_MIE, 32'h1);

        // Trap beats a same-cycle mepc write and a same-cycle MRET
        step(); trap_take = 1'b1; mret = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'h5;
        csr_acc(2'b01, 12'h341, 32'hDEAD_0000, 1'b0); expect_v(K_ILL, 32'h0);
        step(); csr_addr = 12'h300;
        expect_v(K_MEPC, 32'h2000); expect_v(K_RDATA, 32'h80); expect_v(K_MIE, 32'h0);
        step(); csr_addr = 12'h342; expect_v(K_RDATA, 32'h5);
        step(); csr_acc(2'b01, 12'h341, 32'h0000_3007, 1'b0);
        step(); csr_addr = 12'h341; expect_v(K_RDATA, 32'h3004); expect_v(K_MEPC, 32'h3004);

        // mcycle wrap
        step(); csr_acc(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0);
        step(); csr_acc(2'b01, 12'hB00, 32'hFFFF_FFFE, 1'b0);
        step(); csr_addr = 12'hB00; expect_v(K_RDATA, 32'hFFFF_FFFE);
        step(); csr_addr = 12'hB80; expect_v(K_RDATA, 32'hFFFF_FFFF);
        step(); csr_addr = 12'hB00; expect_v(K_RDATA, 32'h0);
        step(); csr_addr = 12'hC80; expect_v(K_RDATA, 32'h0);

        // minstret counts only retire cycles
        step(); csr_addr = 12'hB02; instr_retire = 1'b1; expect_v(K_RDATA, 32'd0);
        step(); csr_addr = 12'hB02; expect_v(K_RDATA, 32'd1);
        step(); csr_addr = 12'hB02; instr_retire = 1'b1; expect_v(K_RDATA, 32'd1);
        step(); csr_addr = 12'hB02; instr_retire = 1'b1; expect_v(K_RDATA, 32'd2);
        step(); csr_addr = 12'hB02; expect_v(K_RDATA, 32'd3);
        step(); csr_addr = 12'hC02; expect_v(K_RDATA, 32'd3);

        // Asynchronous reset mid-run
        step(); rst = 1'b0; csr_addr = 12'h340;
        expect_v(K_RDATA, 32'h0); expect_v(K_MTVEC, MTVEC_EXP);
        expect_v(K_MEPC, 32'h0); expect_v(K_MIE, 32'h0);

        step();
        step();
        if (sb_q.size() != 0) begin
            errors += sb_q.size();
            $display("FAIL drain: %0d expectations never compared, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
